spi_controller: RTL and testbench



---
 rtl/spi_controller.sv | 155 +++++++++++++++
 tb/tb_spi_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI initiator: turns one register read/write command into one SPI frame.
// Supports all CPOL/CPHA modes; SCLK half-period is CLK_DIV clk cycles.
module spi_controller #(
  parameter int ADDR_WIDTH = 4,
  parameter int REG_WIDTH  = 8,
  parameter int CLK_DIV    = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [REG_WIDTH-1:0]  cmd_wdata,
  output logic                  rsp_valid,
  output logic [REG_WIDTH-1:0]  rsp_rdata,
  output logic                  busy,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int F  = 8 + REG_WIDTH;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int KW = $clog2(2 * F);

  typedef enum logic [2:0] {
    IDLE, LEAD, XFER, LAG, GAP
  } state_t;

  state_t               state_q;
  logic [DW-1:0]        div_q;
  logic [KW-1:0]        k_q;
  logic [1:0]           mode_q;
  logic [F-1:0]         tx_q;
  logic [REG_WIDTH-1:0] rx_q;
  logic [1:0]           sync_q;
  logic                 cs_n_q;
  logic                 sclk_q;
  logic                 mosi_q;
  logic                 ready_q;
  logic                 rsp_valid_q;
  logic [REG_WIDTH-1:0] rdata_q;

  logic                 tick_d;
  logic                 lead_d;
  logic                 last_d;
  logic                 drive_d;
  logic                 sample_d;
  logic [REG_WIDTH-1:0] wd_d;
  logic [F-1:0]         frame_d;

  // Edge timing and per-mode drive/sample selection for the current SCLK edge
  always_comb begin
    tick_d   = (div_q == DW'(CLK_DIV - 1));
    lead_d   = ~k_q[0];
    last_d   = (k_q == KW'(2 * F - 1));
    drive_d  = mode_q[0] ? lead_d : (~lead_d & ~last_d);
    sample_d = mode_q[0] ? ~lead_d : lead_d;
    wd_d     = cmd_write ? cmd_wdata : '0;
    frame_d  = {cmd_write, 3'b000, 4'(cmd_addr), wd_d};
  end

  // Frame sequencer with all SPI pins and handshake outputs registered
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= IDLE;
      div_q       <= '0;
      k_q         <= '0;
      mode_q      <= 2'b00;
      tx_q        <= '0;
      rx_q        <= '0;
      sync_q      <= 2'b00;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else if (ena) begin
      sync_q      <= {sync_q[0], spi_miso};
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q <= LEAD;
            mode_q  <= mode;
            cs_n_q  <= 1'b0;
            sclk_q  <= mode[1];
            ready_q <= 1'b0;
            div_q   <= '0;
            k_q     <= '0;
            if (!mode[0]) begin
              mosi_q <= frame_d[F-1];
              tx_q   <= {frame_d[F-2:0], 1'b0};
            end else begin
              tx_q   <= frame_d;
            end
          end
        end
        LEAD, XFER: begin
          if (tick_d) begin
            div_q   <= '0;
            k_q     <= k_q + 1'b1;
            sclk_q  <= ~sclk_q;
            state_q <= last_d ? LAG : XFER;
            if (drive_d) begin
              mosi_q <= tx_q[F-1];
              tx_q   <= {tx_q[F-2:0], 1'b0};
            end
            if (sample_d) begin
              rx_q <= {rx_q[REG_WIDTH-2:0], sync_q[1]};
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        LAG: begin
          if (tick_d) begin
            div_q       <= '0;
            state_q     <= GAP;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= rx_q;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        GAP: begin
          if (tick_d) begin
            div_q   <= '0;
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = ~ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_clk   = sclk_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: table of directed frames against a
// behavioural SPI register peripheral, plus reset/enable/back-to-back cases.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       ena = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [3:0] cmd_addr = 4'h0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;

  spi_controller #(
    .ADDR_WIDTH(4), .REG_WIDTH(8), .CLK_DIV(8)
  ) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Peripheral model: 16 registers, command byte then data byte
  logic [1:0]  m_mode = 2'b00;
  logic [7:0]  regs [16];
  logic [7:0]  p_in = 8'h00;
  logic [7:0]  p_out = 8'h00;
  logic [15:0] p_frame = 16'h0000;
  int          p_cnt = 0;
  logic        p_w = 1'b0;
  logic [3:0]  p_a = 4'h0;
  logic        p_sclk = 1'b0;
  logic        p_cs = 1'b1;

  always @(negedge clk) begin
    if (spi_cs_n) begin
      p_cnt    = 0;
      spi_miso = 1'b0;
    end else if (!p_cs && spi_clk !== p_sclk) begin
      if ((spi_clk !== m_mode[1]) ^ m_mode[0]) begin
        p_in    = {p_in[6:0], spi_mosi};
        p_frame = {p_frame[14:0], spi_mosi};
        p_cnt++;
        if (p_cnt == 8) begin
          p_w   = p_in[7];
          p_a   = p_in[3:0];
          p_out = regs[p_in[3:0]];
        end
        if (p_cnt == 16 && p_w) regs[p_a] = p_in;
      end else if (p_cnt >= 8 && p_cnt < 16) begin
        spi_miso = p_out[7];
        p_out    = {p_out[6:0], 1'b0};
      end
    end
    p_sclk = spi_clk;
    p_cs   = spi_cs_n;
  end

  int         r_tcs, r_trsp, r_trdy, r_edges, r_first;
  int         r_nrsp, r_ov, r_frz;
  logic [7:0] r_rdata;

  // n counts clk edges after the accept edge; n=0 is "T+1"
  task automatic do_frame(input logic [1:0] md, input logic w,
                          input logic [3:0] a, input logic [7:0] wd,
                          input bit hold, input bit pre,
                          input int ena_at, input int rst_at);
    int   n;
    int   wt;
    logic prev;
    logic s_cs, s_clk, s_mosi;
    r_tcs = -1; r_trsp = -1; r_edges = 0; r_first = -1;
    r_nrsp = 0; r_ov = 0; r_frz = 0; r_rdata = 8'h00;
    s_cs = 1'b1; s_clk = 1'b0; s_mosi = 1'b0;
    m_mode = md;
    if (!pre) begin
      wt = 0;
      while (cmd_ready !== 1'b1 && wt < 1000) begin
        @(negedge clk);
        wt++;
      end
      if (wt >= 1000) chk("ready_wait_timeout", 1, 0);
      @(negedge clk);
      mode = md; cmd_write = w; cmd_addr = a;
      cmd_wdata = wd; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!hold) cmd_valid = 1'b0;
    chk("cs_fall_T1", spi_cs_n, 0);
    chk("ready_drop_T1", cmd_ready, 0);
    n = 0;
    prev = spi_clk;
    while (cmd_ready !== 1'b1 && n < 600) begin
      if (n == rst_at) rstb = 1'b0;
      if (n == ena_at) begin
        s_cs = spi_cs_n; s_clk = spi_clk; s_mosi = spi_mosi;
        ena = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (ena_at >= 0 && n > ena_at && n <= ena_at + 20) begin
        if (spi_cs_n !== s_cs || spi_clk !== s_clk ||
            spi_mosi !== s_mosi || rsp_valid !== 1'b0)
          r_frz++;
        if (n == ena_at + 20) ena = 1'b1;
      end
      if (spi_clk !== prev) begin
        r_edges++;
        if (r_first < 0) r_first = n;
      end
      prev = spi_clk;
      if (spi_cs_n === 1'b1 && r_tcs < 0) r_tcs = n;
      if (rsp_valid === 1'b1) begin
        r_nrsp++;
        r_trsp = n;
        r_rdata = rsp_rdata;
        if (cmd_ready === 1'b1) r_ov++;
      end
      if (hold && n == 10) begin
        cmd_write = 1'b0;
        cmd_wdata = 8'hFF;
      end
      if (!hold && n == 20) mode = ~md;
    end
    r_trdy = n;
    if (n >= 600) chk("frame_timeout", 1, 0);
  endtask

  task automatic check_std(input string t, input logic [15:0] ef,
                           input logic [7:0] er, input int ecs,
                           input logic cpol);
    chk({t, "_mosi_frame"}, p_frame, ef);
    chk({t, "_rdata"}, r_rdata, er);
    chk({t, "_cs_rise"}, r_tcs, ecs);
    chk({t, "_rsp_at"}, r_trsp, ecs);
    chk({t, "_rsp_count"}, r_nrsp, 1);
    chk({t, "_ready_at"}, r_trdy, ecs + 8);
    chk({t, "_edges"}, r_edges, 32);
    chk({t, "_first_edge"}, r_first, 8);
    chk({t, "_rsp_ready_overlap"}, r_ov, 0);
    chk({t, "_sclk_idle"}, spi_clk, cpol);
    chk({t, "_mosi_idle"}, spi_mosi, 0);
    chk({t, "_cs_idle"}, spi_cs_n, 1);
  endtask

  typedef struct {
    logic [1:0]  md;
    logic        w;
    logic [3:0]  a;
    logic [7:0]  wd;
    logic [15:0] frame;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    regs[0] = 8'hCA;

    tbl[0]  = '{2'd0, 1'b1, 4'h3, 8'hA5, 16'h83A5, 8'h00};
    tbl[1]  = '{2'd0, 1'b0, 4'h0, 8'h00, 16'h0000, 8'hCA};
    tbl[2]  = '{2'd1, 1'b1, 4'h7, 8'h5A, 16'h875A, 8'h00};
    tbl[3]  = '{2'd1, 1'b0, 4'h7, 8'h33, 16'h0700, 8'h5A};
    tbl[4]  = '{2'd2, 1'b1, 4'h7, 8'h5A, 16'h875A, 8'h5A};
    tbl[5]  = '{2'd2, 1'b0, 4'h7, 8'h00, 16'h0700, 8'h5A};
    tbl[6]  = '{2'd3, 1'b1, 4'h7, 8'h5A, 16'h875A, 8'h5A};
    tbl[7]  = '{2'd3, 1'b0, 4'h7, 8'h00, 16'h0700, 8'h5A};
    tbl[8]  = '{2'd2, 1'b1, 4'h6, 8'h3C, 16'h863C, 8'h00};
    tbl[9]  = '{2'd3, 1'b0, 4'h6, 8'h00, 16'h0600, 8'h3C};
    tbl[10] = '{2'd1, 1'b0, 4'h3, 8'h00, 16'h0300, 8'hA5};

    rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sclk", spi_clk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rstb = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      do_frame(tbl[i].md, tbl[i].w, tbl[i].a, tbl[i].wd, 1'b0, 1'b0, -1, -1);
      check_std($sformatf("vec%0d", i), tbl[i].frame, tbl[i].rd,
                264, tbl[i].md[1]);
    end

    // Back-to-back with cmd_valid held; fields changed while busy
    do_frame(2'd0, 1'b1, 4'h2, 8'h77, 1'b1, 1'b0, -1, -1);
    check_std("b2b_first", 16'h8277, 8'h00, 264, 1'b0);
    @(posedge clk);
    #1;
    do_frame(2'd0, 1'b0, 4'h2, 8'h00, 1'b0, 1'b1, -1, -1);
    check_std("b2b_second", 16'h0200, 8'h77, 264, 1'b0);

    // Enable dropped for 20 cycles mid-frame
    do_frame(2'd0, 1'b1, 4'h5, 8'h11, 1'b0, 1'b0, 49, -1);
    check_std("ena_hold", 16'h8511, 8'h00, 284, 1'b0);
    chk("ena_hold_frozen", r_frz, 0);

    // Reset mid-frame at T+100 in a cpol=1 mode
    do_frame(2'd2, 1'b1, 4'h9, 8'h99, 1'b0, 1'b0, -1, 99);
    chk("abort_at", r_trdy, 100);
    chk("abort_cs_n", spi_cs_n, 1);
    chk("abort_sclk", spi_clk, 0);
    chk("abort_mosi", spi_mosi, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_count", r_nrsp, 0);
    rstb = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_no_rsp", rsp_valid, 0);
    end
    do_frame(2'd0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, -1, -1);
    check_std("after_abort", 16'h0000, 8'hCA, 264, 1'b0);
    do_frame(2'd0, 1'b0, 4'h9, 8'h00, 1'b0, 1'b0, -1, -1);
    check_std("aborted_write", 16'h0900, 8'h00, 264, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
